// File: rtl/scroll_display_if.sv
// Bus bundle for scroll_display: display control, message/length writes and decoder outputs.
interface scroll_display_if;
  logic        scroll_en;
  logic [23:0] pass_in;
  logic        msg_we;
  logic [3:0]  msg_addr;
  logic [3:0]  msg_data;
  logic        len_we;
  logic [4:0]  len_data;
  logic [23:0] digit_out;
  logic        step_led;
  logic        wrap;

  modport master (
    output scroll_en, pass_in, msg_we, msg_addr, msg_data, len_we, len_data,
    input  digit_out, step_led, wrap
  );

  modport slave (
    input  scroll_en, pass_in, msg_we, msg_addr, msg_data, len_we, len_data,
    output digit_out, step_led, wrap
  );
endinterface

// File: rtl/scroll_display.sv
// Six-digit display source: live pass-through or a scrolling message from a writable store.
// Optional SCROLL_WRAP_PAUSE_EN holds position 0 for PAUSE_TICKS extra ticks after a wrap.
module scroll_display #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned MSG_DEPTH   = 16,
  parameter int unsigned PAUSE_TICKS = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  scroll_display_if.slave   bus
);

  localparam int unsigned     PS_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [4:0]      LEN_MAX = 5'(MSG_DEPTH);

  function automatic logic [3:0] init_code(int unsigned i);
    case (i)
      0:       init_code = 4'd6;
      1:       init_code = 4'd0;
      2:       init_code = 4'd15;
      3:       init_code = 4'd10;
      4:       init_code = 4'd11;
      5:       init_code = 4'd12;
      6:       init_code = 4'd12;
      7:       init_code = 4'd5;
      default: init_code = 4'd15;
    endcase
  endfunction

  logic [3:0]      msg [16];
  logic [4:0]      len;
  logic [3:0]      pos;
  logic [PS_W-1:0] presc;
  logic            en_q;
  logic [23:0]     digit_q;
  logic            step_q;
  logic            wrap_q;

  logic            rise;
  logic            tick;
  logic            last;
  logic            shrink;
  logic            paused;
  logic [4:0]      len_new;
  logic [23:0]     disp;
  logic [3:0]      idx;

  assign rise    = bus.scroll_en & ~en_q;
  assign tick    = bus.scroll_en & ~rise & (presc == PS_LAST) & (len != 5'd0);
  assign len_new = (bus.len_data > LEN_MAX) ? LEN_MAX : bus.len_data;
  assign shrink  = bus.scroll_en & bus.len_we & ({1'b0, pos} >= len_new);
  assign last    = ({1'b0, pos} + 5'd1) >= len;

`ifdef SCROLL_WRAP_PAUSE_EN
  localparam int unsigned PC_W = (PAUSE_TICKS > 0) ? $clog2(PAUSE_TICKS + 1) : 1;
  logic [PC_W-1:0] pause_cnt;

  assign paused = (pause_cnt != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pause_cnt <= '0;
    end else if (rise) begin
      pause_cnt <= '0;
    end else if (!shrink && tick) begin
      if (paused)
        pause_cnt <= pause_cnt - 1'b1;
      else if (last)
        pause_cnt <= PC_W'(PAUSE_TICKS);
    end
  end
`else
  assign paused = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      en_q  <= 1'b0;
      presc <= '0;
    end else begin
      en_q <= bus.scroll_en;
      if (!bus.scroll_en || rise || presc == PS_LAST)
        presc <= '0;
      else
        presc <= presc + 1'b1;
    end
  end

  // Entry into scroll mode and a shrinking length both restart at 0 silently; only a tick wraps.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pos    <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      step_q <= step_q ^ tick;
      if (rise || shrink) begin
        pos <= '0;
      end else if (tick && !paused) begin
        if (last) begin
          pos    <= '0;
          wrap_q <= 1'b1;
        end else begin
          pos <= pos + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 16; i++)
        msg[i] <= init_code(i);
      len <= 5'd9;
    end else begin
      if (bus.msg_we && ({1'b0, bus.msg_addr} < LEN_MAX))
        msg[bus.msg_addr] <= bus.msg_data;
      if (bus.len_we)
        len <= len_new;
    end
  end

  // Walk the store from pos with an incremental wrap instead of a modulo; pos restarts at 0 on entry.
  always_comb begin
    disp = '1;
    idx  = rise ? 4'd0 : pos;
    if (!bus.scroll_en) begin
      disp = bus.pass_in;
    end else if (len != 5'd0) begin
      for (int unsigned i = 0; i < 6; i++) begin
        disp[4*(5-i) +: 4] = msg[idx];
        idx = (({1'b0, idx} + 5'd1) >= len) ? 4'd0 : idx + 4'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      digit_q <= '1;
    else
      digit_q <= disp;
  end

  assign bus.digit_out = digit_q;
  assign bus.step_led  = step_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: doc/scroll_display.md
Name: scroll_display

Overview:
- Display-side stage between the game's score/high-score digit selection and the six BCD-to-7-segment decoders.
- Selects either six live score nibbles (pass-through) or a scrolling message of up to 16 nibble codes, advanced once per prescaled tick.
- Replaces the ad-hoc scroll case statement and per-digit scroll muxes with one block holding a writable message store.
- Code 15 is the blank glyph; codes 10–12 are letter glyphs in the decoder.

Parameters:
- TICK_DIV, 50000000, clock cycles per scroll step; 1 s at 50 MHz; minimum 2.
- MSG_DEPTH, 16, message store entries, each 4 bits; maximum 16.
- PAUSE_TICKS, 2, extra ticks held at position 0 after a wrap; used only with SCROLL_WRAP_PAUSE_EN.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- scroll_en  in  1  1 = scroll message, 0 = pass-through.
- pass_in  in  24  live digits; [23:20]=seg5 (leftmost) … [3:0]=seg0.
- msg_we  in  1  message write strobe, one entry per cycle.
- msg_addr  in  4  write address.
- msg_data  in  4  write data.
- len_we  in  1  length write strobe.
- len_data  in  5  message length, 0..16.
- digit_out  out  24  to decoders; same packing as pass_in.
- step_led  out  1  toggles on every scroll step.
- wrap  out  1  one-cycle pulse when position returns to 0.

Behaviour:
- Interface: one clock, clock. Reset reset_n is asynchronous and active-low.
- Reset values:
  - digit_out = 24'hFFFFFF (all blank); step_led = 0; wrap = 0.
  - Position pos = 0; prescaler = 0.
  - Message store = 6,0,15,10,11,12,12,5,15, then 15 in the remaining entries; length = 9.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while scroll_en = 1.
  - The tick is asserted for one cycle at terminal count; the prescaler then returns to 0.
  - Held at 0 while scroll_en = 0.
- Position on each tick: pos <= (pos+1 == len) ? 0 : pos+1. step_led toggles.
- wrap pulses on the same cycle pos is loaded with 0 by a tick. It does not pulse on reset or entry into scroll mode.
- Rising edge of scroll_en (registered copy 0 → 1): pos <= 0 and prescaler <= 0 in the same cycle. The first tick follows TICK_DIV cycles later.
- Output mapping in scroll mode, with i = 0..5 and index = (pos+i) mod len:
  - seg(5-i) nibble = msg[index].
  - seg5 = msg[pos]; seg0 = msg[pos+5], wrapped.
- Length boundaries:
  - len = 0: all digits = 15. No ticks advance pos; step_led and wrap are frozen.
  - len = 1..5: indices wrap repeatedly, so the message repeats across the digits.
  - len_data > 16 is clamped to 16.
  - len_we while scrolling: if pos >= new len, pos <= 0 on the same cycle, without a wrap pulse.
- Pass-through mode: digit_out <= pass_in. pos and step_led hold their values.
- digit_out is registered in both modes. Latency is 1 cycle from any change in pass_in, pos, msg or len to digit_out.
- Message writes:
  - msg_we writes msg[msg_addr] <= msg_data. Addresses at or above MSG_DEPTH are ignored.
  - A write in the same cycle as a tick: the new data is used in the output computed on the following cycle. There is no partial or torn display.
  - Simultaneous len_we and msg_we are both applied.
- reset_n asserted mid-scroll: all state returns to reset values immediately, including the message store contents.

Optional Feature:
- Macro: SCROLL_WRAP_PAUSE_EN.
- Defined:
  - After a wrap, the following PAUSE_TICKS ticks do not advance pos.
  - step_led still toggles on every tick.
  - A pause counter of ceil(log2(PAUSE_TICKS+1)) bits is cleared on reset and on the scroll_en rising edge.
- Undefined: every tick advances pos. The pause counter and PAUSE_TICKS have no effect.

Test Plan:
- Reset, then scroll_en=1, TICK_DIV=4:
  - Cycle 1 after entry: digit_out = 24'h60FABC.
  - After the first tick, one cycle later: 24'h0FABCC.
  - After 9 ticks: back to 24'h60FABC, with wrap pulsing once.
- scroll_en=0, pass_in=24'h000123: digit_out = 24'h000123 one cycle later. Toggle scroll_en back to 1: display restarts at 24'h60FABC.
- len_we with len_data=3, writing msg[0..2]=1,2,3: display = 24'h123123; after one tick 24'h231231.
- len_data=0 while scrolling: digit_out = 24'hFFFFFF; step_led and wrap stay frozen for 20 ticks' worth of cycles.
- Mid-scroll at pos=7, load len=5: pos becomes 0 on the same cycle with no wrap pulse. Assert reset_n=0 mid-tick: outputs return to 24'hFFFFFF asynchronously.
- With SCROLL_WRAP_PAUSE_EN, PAUSE_TICKS=2, len=9:
  - After the wrap, 24'h60FABC holds for 3 tick periods.
  - step_led toggles 3 times during the hold.
